uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter NUM_BITS, default 8, data bits per frame.
REQ-002 Parameter CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req  input  1  four-phase request from the upstream producer; tx_data valid while high.
REQ-008 tx_data  input  NUM_BITS  byte to transmit.
REQ-009 ack  output  1  four-phase acknowledge to the producer.
REQ-010 txd  output  1  serial line; idle high.
REQ-011 busy  output  1  high from capture until the stop bit completes.

Function
REQ-012 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE using integer division, truncated; elaboration SHALL fail if CLKS_PER_BIT < 2 or if PARITY > 2.
REQ-013 States SHALL be IDLE, START, DATA, PARITY_BIT, STOP and WAIT_REQ_LOW.
REQ-014 In IDLE, when req=1 and ack=0, tx_data SHALL be latched into the shift register and the FSM SHALL enter START.
- On the next cycle: txd=0, ack=1, busy=1.
REQ-015 Later changes on tx_data SHALL NOT affect the frame in flight.
REQ-016 START, each data bit, PARITY_BIT and STOP SHALL each hold txd for exactly CLKS_PER_BIT cycles, timed by a baud counter reloaded at every state entry.
REQ-017 DATA SHALL send NUM_BITS bits LSB first, using a bit counter of width $clog2(NUM_BITS+1).
REQ-018 PARITY_BIT SHALL be entered only when PARITY != 0.
- txd = XOR of the data bits for even parity.
- txd = inverted XOR for odd parity.
REQ-019 STOP SHALL drive txd=1, then enter WAIT_REQ_LOW; busy SHALL drop on entry to WAIT_REQ_LOW.
REQ-020 In WAIT_REQ_LOW, ack SHALL stay 1 until req=0.
- On the cycle req=0 is seen, ack SHALL be cleared and the FSM SHALL return to IDLE.
- If req is already low when STOP ends, ack SHALL fall one cycle after STOP ends.
REQ-021 Dropping req during START/DATA/PARITY_BIT/STOP SHALL NOT abort the frame; ack SHALL fall only via WAIT_REQ_LOW.
REQ-022 A new capture SHALL require ack=0.
- Minimum frame-to-frame spacing is one IDLE cycle after ack falls.
- A producer holding req high across ack falling SHALL get its next byte captured on the first IDLE cycle.
REQ-023 txd SHALL be driven from a register (glitch-free); no combinational path from req or tx_data to txd.

Reset
REQ-024 When rst_n=0 at a clock edge, on the next cycle: state IDLE, txd=1, ack=0, busy=0, and baud counter, bit counter and shift register all 0.
REQ-025 Reset mid-frame SHALL abort immediately with txd=1; no partial stop bit is owed.

Structure
REQ-026 Shared package serial_pkg SHALL hold:
- SOT=8'd2 and EOT=8'd3;
- the parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
- the uart_tx state enum typedef.
REQ-027 Sub-module baud_gen SHALL contain the baud counter.
- Inputs: clear, enable.
- Output: one-cycle tick on the last cycle of each bit period.
- Parameter: CLKS_PER_BIT.
REQ-028 uart_tx SHALL connect directly to a producer using req/ack/tx_data four-phase signalling, with no glue logic.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10)
REQ-029 PARITY=0; req=1 with tx_data=8'h55.
- txd=0 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then 1 for 10 cycles.
- ack=1 one cycle after capture; total frame 100 cycles.
REQ-030 PARITY=2 with 8'h55: parity bit 0, frame 110 cycles. PARITY=1 with 8'h55: parity bit 1. PARITY=2 with 8'h07: parity bit 1.
REQ-031 Producer drops req 3 cycles after ack rises.
- Frame still completes; ack falls one cycle after STOP ends.
- busy falls on the same cycle as ack.
REQ-032 Producer holds req high 50 cycles past the stop bit; ack stays 1 throughout and falls one cycle after req=0.
REQ-033 Four-byte burst 02,41,42,03 from a four-phase producer model.
- Receiver model decodes exactly 02,41,42,03.
- No capture ever occurs while ack=1.
REQ-034 rst_n=0 during bit 3 of a frame.
- Next cycle: txd=1, ack=0, busy=0.
- After release, a new byte 8'hA5 transmits correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: framing bytes, parity modes, transmitter FSM states.
// Pure declarations; no logic, no latency, no flow control.
package serial_pkg;

  localparam logic [7:0] SOT = 8'd2;
  localparam logic [7:0] EOT = 8'd3;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP,
    WAIT_REQ_LOW
  } tx_state_e;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: tick_o pulses on the last cycle of every CLKS_PER_BIT-cycle period.
// Counter restarts from zero after each tick and while clear_i is high; never stalls its user.
module baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q;

  assign tick_o = enable_i && !clear_i && (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Wrapping on tick is what reloads the period at every FSM state entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with four-phase req/ack capture; frame starts one cycle after capture.
// A new byte is accepted only after ack has fallen; req dropping mid-frame never aborts it.
module uart_tx
  import serial_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                ack,
  output logic                txd,
  output logic                busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BCW          = $clog2(NUM_BITS + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  tx_state_e           state_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic                par_q;
  logic                txd_q;
  logic                ack_q;
  logic                busy_q;
  logic                baud_clear;
  logic                bit_tick;

  assign baud_clear = (state_q == IDLE) || (state_q == WAIT_REQ_LOW);

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (baud_clear),
    .enable_i(!baud_clear),
    .tick_o  (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !ack_q) begin
            shift_q   <= tx_data;
            par_q     <= ^tx_data;
            bit_cnt_q <= '0;
            txd_q     <= 1'b0;
            ack_q     <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= BCW'(1);
            state_q   <= DATA;
          end
        end
        DATA: begin
          // bit_cnt_q counts bits already placed on the line, including the current one
          if (bit_tick) begin
            if (bit_cnt_q == BCW'(NUM_BITS)) begin
              if (PARITY != PAR_NONE) begin
                txd_q   <= (PARITY == PAR_EVEN) ? par_q : ~par_q;
                state_q <= PARITY_BIT;
              end else begin
                txd_q   <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        PARITY_BIT: begin
          if (bit_tick) begin
            txd_q   <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          // A producer that already released req sees ack fall together with busy
          if (bit_tick) begin
            busy_q  <= 1'b0;
            state_q <= WAIT_REQ_LOW;
            if (!req) begin
              ack_q <= 1'b0;
            end
          end
        end
        WAIT_REQ_LOW: begin
          if (!req || !ack_q) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd  = txd_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/odd/even parity) at 10 clocks per bit, driven by
// directed four-phase transactions; a line receiver pops expected frames from a scoreboard.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [7:0] tx_data [3];
  logic [2:0] ack;
  logic [2:0] txd;
  logic [2:0] busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] data;
    logic       par_en;
    logic       par;
    logic       abort;
  } exp_t;

  exp_t exp_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(
      .NUM_BITS (8),
      .CLK_FREQ (1_000_000),
      .BAUD_RATE(100_000),
      .PARITY   (g)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req[g]),
      .tx_data(tx_data[g]),
      .ack    (ack[g]),
      .txd    (txd[g]),
      .busy   (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int inst, input logic [7:0] d, input logic p, input logic ab);
    exp_t e;
    e.inst   = 2'(inst);
    e.data   = d;
    e.par_en = (inst != 0);
    e.par    = p;
    e.abort  = ab;
    exp_q.push_back(e);
  endtask

  // Directed transaction; hold=0 drops req 3 cycles after ack rises, hold=1 keeps it 50 cycles past stop
  task automatic send_directed(input int inst, input logic [7:0] d, input logic p,
                               input int flen, input bit hold);
    int n;
    int ack_low;
    int hold_bad;
    push_exp(inst, d, p, 1'b0);
    tx_data[inst] = d;
    req[inst]     = 1'b1;
    tick();
    check($sformatf("inst%0d ack_after_capture", inst), ack[inst], 1);
    check($sformatf("inst%0d busy_after_capture", inst), busy[inst], 1);
    check($sformatf("inst%0d txd_start", inst), txd[inst], 0);
    tx_data[inst] = ~d;
    n       = 0;
    ack_low = 0;
    while (busy[inst] === 1'b1 && n < 400) begin
      if (!hold && n == 3) req[inst] = 1'b0;
      tick();
      n++;
      if (busy[inst] === 1'b1 && ack[inst] !== 1'b1) ack_low++;
    end
    check($sformatf("inst%0d frame_len", inst), n, flen);
    check($sformatf("inst%0d ack_low_midframe", inst), ack_low, 0);
    if (!hold) begin
      check($sformatf("inst%0d ack_falls_with_busy", inst), ack[inst], 0);
    end else begin
      check($sformatf("inst%0d ack_held_at_stop_end", inst), ack[inst], 1);
      hold_bad = 0;
      repeat (50) begin
        tick();
        if (ack[inst] !== 1'b1) hold_bad++;
      end
      check($sformatf("inst%0d ack_held_50", inst), hold_bad, 0);
      req[inst] = 1'b0;
      tick();
      check($sformatf("inst%0d ack_after_req_low", inst), ack[inst], 0);
      check($sformatf("inst%0d busy_after_req_low", inst), busy[inst], 0);
    end
    repeat (3) tick();
  endtask

  // Plain four-phase producer
  task automatic produce(input int inst, input logic [7:0] d, input logic p);
    int n;
    push_exp(inst, d, p, 1'b0);
    tx_data[inst] = d;
    req[inst]     = 1'b1;
    n = 0;
    while (ack[inst] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("inst%0d hs_ack_rise", inst), ack[inst], 1);
    req[inst]     = 1'b0;
    tx_data[inst] = 8'h00;
    n = 0;
    while (ack[inst] !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check($sformatf("inst%0d hs_ack_fall", inst), ack[inst], 0);
  endtask

  task automatic receive_frame(input int i);
    exp_t       e;
    logic [10:0] seq;
    int          nper;
    int          bad;
    logic        v;
    check($sformatf("inst%0d sb_frame_expected", i), exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("sb_inst", i, e.inst);
    seq[0] = 1'b0;
    for (int k = 0; k < 8; k++) seq[1+k] = e.data[k];
    if (e.par_en) begin
      seq[9]  = e.par;
      seq[10] = 1'b1;
      nper    = 11;
    end else begin
      seq[9]  = 1'b1;
      seq[10] = 1'b1;
      nper    = 10;
    end
    for (int p = 0; p < nper; p++) begin
      bad = 0;
      v   = 1'bx;
      for (int s = 0; s < 10; s++) begin
        if (!(p == 0 && s == 0)) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            check($sformatf("inst%0d abort_expected", i), e.abort, 1);
            return;
          end
        end
        if (s == 0) v = txd[i];
        else if (txd[i] !== v) bad++;
      end
      if (p == nper - 1) check($sformatf("inst%0d busy_in_stop", i), busy[i], 1);
      check($sformatf("inst%0d data%02h period%0d {unstable,bit}", i, e.data, p),
            {bad != 0, v}, {1'b0, seq[p]});
    end
    @(negedge clk);
    check($sformatf("inst%0d idle_after_stop", i), txd[i], 1);
    check($sformatf("inst%0d busy_low_after_stop", i), busy[i], 0);
    check($sformatf("inst%0d abort_flag", i), e.abort, 0);
  endtask

  initial begin : monitor
    logic [2:0] prev_txd;
    prev_txd = 3'b111;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_n === 1'b1 && prev_txd[i] === 1'b1 && txd[i] === 1'b0) receive_frame(i);
      end
      prev_txd = txd;
    end
  end

  initial begin : capture_guard
    logic [2:0] prev_busy;
    logic [2:0] prev_ack;
    prev_busy = 3'b000;
    prev_ack  = 3'b000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_n === 1'b1 && busy[i] === 1'b1 && prev_busy[i] === 1'b0)
          check($sformatf("inst%0d ack_low_before_capture", i), prev_ack[i], 0);
      end
      prev_busy = busy;
      prev_ack  = ack;
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    req   = 3'b000;
    for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("inst%0d reset_txd", i), txd[i], 1);
      check($sformatf("inst%0d reset_ack", i), ack[i], 0);
      check($sformatf("inst%0d reset_busy", i), busy[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    send_directed(0, 8'h55, 1'b0, 100, 1'b0);
    send_directed(2, 8'h55, 1'b0, 110, 1'b1);
    send_directed(1, 8'h55, 1'b1, 110, 1'b0);
    send_directed(2, 8'h07, 1'b1, 110, 1'b0);
    send_directed(1, 8'h00, 1'b1, 110, 1'b0);
    send_directed(0, 8'h80, 1'b0, 100, 1'b1);

    produce(0, 8'h02, 1'b0);
    produce(0, 8'h41, 1'b0);
    produce(0, 8'h42, 1'b0);
    produce(0, 8'h03, 1'b0);
    produce(1, 8'h41, 1'b1);
    produce(2, 8'h03, 1'b0);

    push_exp(0, 8'hC3, 1'b0, 1'b1);
    tx_data[0] = 8'hC3;
    req[0]     = 1'b1;
    tick();
    repeat (45) tick();
    rst_n  = 1'b0;
    req[0] = 1'b0;
    tick();
    check("midframe_reset_txd", txd[0], 1);
    check("midframe_reset_ack", ack[0], 0);
    check("midframe_reset_busy", busy[0], 0);
    rst_n = 1'b1;
    tick();
    produce(0, 8'hA5, 1'b0);
    produce(2, 8'hA5, 1'b0);

    repeat (20) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
